// File: rtl/pio_arb_pkg.sv
// Shared types and soc PIO word addresses for the PIO write arbiter.
package pio_arb_pkg;

    typedef enum logic {IDLE, WRITE} arb_state_t;

    localparam int unsigned PIO_ADDR_W = 4;

    localparam logic [PIO_ADDR_W-1:0] ADDR_HEX0 = 4'd0;
    localparam logic [PIO_ADDR_W-1:0] ADDR_HEX1 = 4'd1;
    localparam logic [PIO_ADDR_W-1:0] ADDR_HEX2 = 4'd2;
    localparam logic [PIO_ADDR_W-1:0] ADDR_HEX3 = 4'd3;
    localparam logic [PIO_ADDR_W-1:0] ADDR_LEDR = 4'd4;
    localparam logic [PIO_ADDR_W-1:0] ADDR_SW   = 4'd5;

endpackage

// File: rtl/pio_write_arbiter_if.sv
// Requester-side valid/ready bus plus the shared Avalon-MM write master.
interface pio_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         avm_address;
    logic                      avm_write;
    logic [DATA_W-1:0]         avm_writedata;
    logic                      avm_waitrequest;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;

    // Arbiter side: it is the Avalon master.
    modport master (
        input  req_valid, req_addr, req_data, avm_waitrequest,
        output req_ready, avm_address, avm_write, avm_writedata, grant_id, busy
    );

    modport slave (
        output req_valid, req_addr, req_data, avm_waitrequest,
        input  req_ready, avm_address, avm_write, avm_writedata, grant_id, busy
    );

endinterface

// File: rtl/rr_select.sv
// Combinational rotate-priority encoder: first set bit of req searching
// upward from last_grant+1 with wrap.
module rr_select #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         onehot,
    output logic [$clog2(NUM_REQ)-1:0] index,
    output logic                       any
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                index        = cand;
            end
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM write master among NUM_REQ
// valid/ready requesters; one latched write per grant.
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32
) (
    input logic                clk,
    input logic                reset_n,
    pio_write_arbiter_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t       state_q, state_d;
    logic             write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0]   sel_index;
    logic               sel_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .onehot     (sel_onehot),
        .index      (sel_index),
        .any        (sel_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_onehot[i]) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    state_d = WRITE;
                    write_d = 1'b1;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    grant_d = sel_index;
                end
            end
            WRITE: begin
                if (!bus.avm_waitrequest) begin
                    state_d      = IDLE;
                    write_d      = 1'b0;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Gated by reset_n so no accept strobe is shown while held in reset.
    assign bus.req_ready     = (state_q == IDLE && reset_n) ? sel_onehot : '0;
    assign bus.avm_write     = write_q;
    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = data_q;
    assign bus.grant_id      = grant_q;
    assign bus.busy          = (state_q == WRITE);

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: directed scenarios then random traffic.
module tb_pio_write_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 32;

    typedef struct {
        int                id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pio_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pio_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [NUM_REQ-1:0] v_r = '0;
    logic [ADDR_W-1:0]  a_r [NUM_REQ];
    logic [DATA_W-1:0]  d_r [NUM_REQ];
    logic               wr_r = 1'b0;
    bit                 refill = 1'b0;
    bit                 got_acc;

    always_comb begin
        bus.req_valid       = v_r;
        bus.req_addr        = '0;
        bus.req_data        = '0;
        bus.avm_waitrequest = wr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W] = a_r[i];
            bus.req_data[i*DATA_W +: DATA_W] = d_r[i];
        end
    end

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration state in plain integers.
    int                 m_last = NUM_REQ - 1;
    int                 m_gid = 0;
    bit                 m_busy = 1'b0;
    logic [NUM_REQ-1:0] accepted = '0;
    exp_t               exp_q[$];

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] er;
        int pick;
        int c;
        if (!reset_n) begin
            m_busy   = 1'b0;
            m_last   = NUM_REQ - 1;
            m_gid    = 0;
            accepted = '0;
            exp_q.delete();
        end else begin
            check("busy", 64'(bus.busy), 64'(m_busy));
            check("avm_write", 64'(bus.avm_write), 64'(m_busy));
            check("grant_id", 64'(bus.grant_id), 64'(m_gid));
            er   = '0;
            pick = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_last + k) % NUM_REQ;
                    if (pick < 0 && v_r[c]) pick = c;
                end
            end
            if (pick >= 0) er[pick] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(er));
            accepted = er;
            if (pick >= 0) begin
                exp_q.push_back('{pick, a_r[pick], d_r[pick]});
                m_busy = 1'b1;
                m_gid  = pick;
            end else if (m_busy && !wr_r) begin
                m_busy = 1'b0;
                m_last = m_gid;
            end
        end
    end

    // Monitor: every Avalon write cycle must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (reset_n && bus.avm_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h id %0h, expected no write",
                         bus.avm_address, bus.avm_writedata, bus.grant_id);
            end else begin
                check("wr_addr", 64'(bus.avm_address), 64'(exp_q[0].addr));
                check("wr_data", 64'(bus.avm_writedata), 64'(exp_q[0].data));
                check("wr_id", 64'(bus.grant_id), 64'(exp_q[0].id));
                if (!bus.avm_waitrequest) begin
                    void'(exp_q.pop_front());
                    n_writes++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        got_acc = |accepted;
        v_r = v_r & ~accepted;
        if (refill) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!v_r[i]) begin
                    v_r[i] = 1'b1;
                    a_r[i] = ADDR_W'($urandom);
                    d_r[i] = $urandom;
                end
            end
        end
    endtask

    task automatic wait_accept(string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!got_acc && n < 30);
        checks++;
        if (!got_acc) begin
            errors++;
            $display("FAIL %s: got no accept within 30 cycles, expected one", name);
        end
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((m_busy || (|v_r)) && n < 60) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (m_busy || (|v_r)) begin
            errors++;
            $display("FAIL %s: got pending traffic after 60 cycles, expected idle", name);
        end
    endtask

    task automatic set_req(int i, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        v_r[i] = 1'b1;
        a_r[i] = a;
        d_r[i] = d;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_r[i] = '0;
            d_r[i] = '0;
        end
        #2;
        check("rst_avm_write", 64'(bus.avm_write), 64'd0);
        check("rst_avm_address", 64'(bus.avm_address), 64'd0);
        check("rst_avm_writedata", 64'(bus.avm_writedata), 64'd0);
        check("rst_grant_id", 64'(bus.grant_id), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single request, immediate completion.
        set_req(0, 4'd2, 32'h3F);
        wait_accept("single_accept");
        wait_idle("single_idle");

        // All four continuously valid: strict 0,1,2,3 rotation.
        refill = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'($urandom), $urandom);
        for (int c = 0; c < 16; c++) tick();
        refill = 1'b0;
        v_r = '0;
        wait_idle("rotate_idle");

        // Park last grant on 0, then stall requester 1's write for three edges.
        set_req(0, 4'd4, 32'h1);
        wait_accept("park0_accept");
        wait_idle("park0_idle");
        set_req(1, 4'd1, 32'h55);
        set_req(2, 4'd2, 32'h66);
        set_req(3, 4'd3, 32'h77);
        wr_r = 1'b1;
        wait_accept("stall_accept");
        for (int c = 0; c < 3; c++) tick();
        wr_r = 1'b0;
        wait_idle("stall_idle");

        // Wrap-around search and priority after the wrap.
        set_req(3, 4'd3, 32'h33);
        wait_accept("wrap3_accept");
        wait_idle("wrap3_idle");
        set_req(2, 4'd2, 32'h22);
        wait_accept("wrap2_accept");
        wait_idle("wrap2_idle");
        set_req(0, 4'd0, 32'hA0);
        set_req(2, 4'd2, 32'hA2);
        wait_accept("pair_accept");
        wait_idle("pair_idle");

        // Requester 3 withdraws while requester 1 owns the bus.
        set_req(1, 4'd1, 32'h11);
        wr_r = 1'b1;
        wait_accept("withdraw_accept");
        tick();
        set_req(3, 4'd5, 32'hDEAD);
        tick();
        v_r[3] = 1'b0;
        tick();
        wr_r = 1'b0;
        wait_idle("withdraw_idle");

        // Reset in the middle of a stalled write.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 8), 32'hB0 + 32'(i));
        wr_r = 1'b1;
        wait_accept("rstmid_accept");
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_avm_write", 64'(bus.avm_write), 64'd0);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_req_ready", 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 8), 32'hC0 + 32'(i));
        wr_r = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_idle("rstmid_idle");

        // Random traffic with random stalls and withdrawals.
        for (int c = 0; c < 600; c++) begin
            tick();
            wr_r = ($urandom_range(2) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!v_r[i]) begin
                    if ($urandom_range(2) == 0) set_req(i, ADDR_W'($urandom), $urandom);
                end else if ($urandom_range(15) == 0) begin
                    v_r[i] = 1'b0;
                end
            end
        end
        wr_r = 1'b0;
        wait_idle("random_idle");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("writes_seen", 64'(n_writes > 100), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_write_arbiter.md
Name: pio_write_arbiter

Overview:
- Round-robin arbiter that shares the single Avalon-MM write master into the soc PIO fabric (HEX0-3, LEDR registers) among NUM_REQ independent requesters, e.g. a score logic block, a debug mux and a switch-echo unit.
- Each requester presents a valid/ready write request; the arbiter grants one requester, latches its address and data, and drives one Avalon write, holding it while waitrequest is high.
- Sits in de1soc_top between the user logic and the soc Avalon bridge.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, Avalon word-address width.
- DATA_W, 32, Avalon write-data width.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; same packing as req_addr.
- req_ready  output  NUM_REQ  one-hot accept strobe.
- avm_address  output  ADDR_W  Avalon address.
- avm_write  output  1  Avalon write strobe.
- avm_writedata  output  DATA_W  Avalon write data.
- avm_waitrequest  input  1  Avalon stall.
- grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current or last write.
- busy  output  1  high while in WRITE state.

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE.
  - avm_write=0, avm_address=0, avm_writedata=0.
  - grant_id=0, busy=0, req_ready=0.
  - last_grant=NUM_REQ-1, so requester 0 has highest priority after reset.
- FSM states: IDLE, WRITE.
- IDLE:
  - Select the first i with req_valid[i]=1, searching last_grant+1, last_grant+2, … with modulo-NUM_REQ wrap.
  - req_ready is combinational: req_ready[i]=1 only for the selected i, only in IDLE; all zero otherwise.
  - A transfer occurs on the edge where valid&ready.
  - On that edge: latch the selected addr/data into avm_address/avm_writedata, set grant_id=i, avm_write=1, busy=1, go to WRITE.
  - No valid requests: remain in IDLE, outputs hold, avm_write=0.
- WRITE:
  - avm_write, avm_address and avm_writedata are held stable while avm_waitrequest=1.
  - On the first edge with avm_waitrequest=0: avm_write=0, busy=0, last_grant=grant_id, go to IDLE.
  - req_ready=0 throughout WRITE; requests arriving here wait.
- Latency and throughput:
  - Request accepted in cycle T; avm_write high from T+1.
  - With waitrequest=0 the write completes at the end of T+1; the next accept is possible in T+2.
  - Maximum rate: one write per 2 cycles.
- Requester contract: hold req_valid, addr and data stable until req_ready. Deasserting valid before ready is permitted; the request is simply withdrawn with no side effects.
- Simultaneous requests: exactly one grant per arbitration, strictly round-robin. No requester waits more than NUM_REQ-1 grants while continuously valid.
- Single requester continuously valid: it is granted on every arbitration; its own last_grant does not starve it.
- avm_waitrequest is ignored in IDLE.
- Reset mid-write: the write is abandoned immediately (avm_write=0 asynchronously) and priority returns to requester 0. The Avalon fabric receives no partial-transfer guarantee; this is documented as acceptable.
- grant_id retains its value after completion until the next grant.

Decomposition:
- Package pio_arb_pkg: typedef enum logic {IDLE, WRITE} arb_state_t; constants for soc PIO word addresses (HEX0..HEX3, LEDR, SW).
- One sub-module: rr_select. Combinational rotate-priority encoder.
  - Inputs: req vector, last_grant.
  - Outputs: onehot, index, any.
  - Parameterised by NUM_REQ; reusable by future arbiters.

Test Plan:
- Reset then req_valid=4'b0001, addr=2, data=0x3F, waitrequest=0 -> req_ready=0001 in the accept cycle; next cycle avm_write=1, addr=2, data=0x3F, grant_id=0; following cycle avm_write=0, busy=0.
- req_valid=4'b1111 held for 8 arbitrations, waitrequest=0 -> grant sequence 0,1,2,3,0,1,2,3; exactly one write per 2 cycles.
- Grant requester 1 (data 0x55) with waitrequest=1 for 3 cycles -> avm_write/address/data held 4 cycles unchanged; req_ready stays 0 though req_valid=1110; next grant is requester 2.
- last_grant=3 and req_valid=4'b0100 -> requester 2 granted (search wraps 0,1,2); then req_valid=4'b0101 -> requester 0 granted before requester 2.
- Assert reset_n=0 during WRITE with waitrequest=1 -> avm_write, busy and req_ready drop asynchronously; after release with req_valid=1111, first grant is 0.
- Requester 3 raises valid one cycle then drops it while requester 1 holds the bus -> no write ever issued with requester 3's data; grant_id never 3.
